instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Prefetching instruction fetch stage ahead of the decode/register-file stage of the mips core.
//  Replaces the bare PC + adder path with the following:
//   - issues in-order word requests to a variable-latency instruction memory
//   - buffers returned 64-bit words in a small FIFO
//   - presents them downstream with a valid/ready handshake
//  Supports a single-cycle PC redirect (branch/jump) that flushes buffered and in-flight fetches.
// PARAMETERS
//  RESET_ADR  16'h0000  PC value loaded on reset
//  DEPTH      4         prefetch FIFO entries (power of 2, 2..16); also max outstanding requests
// PORTS
//  clk           in   1   core clock, all state on rising edge
//  rst           in   1   asynchronous reset, active-high
//  redirect_en   in   1   load new PC this cycle, flush pipeline
//  redirect_adr  in   16  target word address
//  imem_req      out  1   request valid
//  imem_adr      out  16  word address of request
//  imem_ack      in   1   request accepted this cycle (req && ack = issue)
//  imem_rvalid   in   1   response valid; one per issued request, in order, latency >= 1
//  imem_rdata    in   64  instruction word
//  ins_valid     out  1   FIFO head valid
//  ins_ready     in   1   decode accepts head (valid && ready = pop)
//  ins_data      out  64  head instruction word
//  ins_pc        out  16  word address of head instruction
// BEHAVIOUR
//  Reset (async): pc=RESET_ADR, FIFO empty, outstanding=0, discard=0, state=RUN.
//   Outputs after reset: imem_req=0 until first clock, ins_valid=0, ins_data=0, ins_pc=0.
//  FSM states:
//   RUN    issue allowed
//   DRAIN  no issue; in-flight responses discarded
//   RUN->DRAIN on redirect_en with outstanding>0 (counting any response arriving same cycle)
//   DRAIN->RUN when discard count reaches 0
//  Issue condition:
//   imem_req = (state==RUN) && !redirect_en && (fifo_count + outstanding < DEPTH)
//   imem_adr = pc; on issue pc <= pc+1, 16-bit wrap (16'hFFFF -> 16'h0000)
//   Each entry records its fetch address; ins_pc is that address.
//  Response handling:
//   imem_rvalid decrements outstanding; word pushed to FIFO unless discard>0 (then discard--).
//   Credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
//  Latency:
//   request issued cycle N, response cycle N+L -> ins_valid at N+L+1 (FIFO registered)
//   Steady throughput: 1 instr/cycle when L < DEPTH.
//  Redirect (priority over all else):
//   - pc <= redirect_adr
//   - FIFO cleared; ins_valid=0 next cycle
//   - discard <= outstanding (minus a same-cycle response)
//   - a pop in the redirect cycle counts as completed
//   - a response arriving in the redirect cycle is dropped
//   - redirect in DRAIN: pc updated, discard unchanged (already covers all in flight), stays DRAIN
//   - redirect with outstanding=0 stays RUN and issues from the new PC next cycle
//  Simultaneous push+pop on a full or empty FIFO is legal; count unchanged.
//  Reset mid-operation: all counters zeroed. Memory responses to pre-reset requests are system-illegal.
// CONFIGURATION
//  IFU_PERF_EN defined: adds the following ports, reset to 0 and saturating at 32'hFFFFFFFF:
//   perf_fetched  out  32  pops
//   perf_stall    out  32  cycles with ins_ready && !ins_valid
//   perf_flush    out  32  redirect count
//  IFU_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package mips_defs:
//   - ADR_W=16, INS_W=64
//   - typedef enum {IFU_RUN, IFU_DRAIN} ifu_state_t
//   - typedef struct {adr, ins} fetch_entry_t (shared with the decode stage)
//  Sub-module ifu_fifo:
//   - parameterised DEPTH x fetch_entry_t
//   - sync clear input, count output
//   - no redirect knowledge
//  Top holds pc, FSM, outstanding and discard counters.
// TESTING
//  T1 reset: rst=1 then release, ins_ready=1, mem L=1 -> imem_adr 0,1,2..; ins_pc 0,1,2 one per cycle; ins_data matches mem.
//  T2 backpressure: ins_ready=0 -> exactly 4 issues (DEPTH=4), imem_req=0 afterwards.
//     Release -> 4 pops in order, fetching resumes.
//  T3 redirect in flight: L=3, redirect_adr=16'h0040 with 3 outstanding -> 3 responses dropped, no ins_valid from them.
//     First delivered ins_pc=16'h0040.
//  T4 redirect edge cases:
//     - redirect coinciding with rvalid and pop -> the response is dropped; next ins_pc=target.
//     - back-to-back redirects 0x10 then 0x20 -> only 0x20 stream delivered.
//  T5 wrap: RESET_ADR=16'hFFFE -> ins_pc FFFE, FFFF, 0000, 0001.
//  T6 IFU_PERF_EN: 10 pops, 2 redirects, 5 starved cycles -> perf_fetched=10, perf_flush=2, perf_stall=5.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the mips core front end: bus widths, the fetch
// stage FSM encoding and the fetch entry handed to the decode stage.
package mips_defs;

   localparam int ADR_W = 16;
   localparam int INS_W = 64;

   typedef enum logic {
      IFU_RUN   = 1'b0,
      IFU_DRAIN = 1'b1
   } ifu_state_t;

   // One fetched instruction together with the word address it came from.
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [INS_W-1:0] ins;
   } fetch_entry_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
      return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of fetch entries. DEPTH must be a power of two so the
// pointers wrap naturally. Synchronous clear empties it in one cycle; the
// head output is forced to zero while the FIFO is empty.
module ifu_fifo
   import mips_defs::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !clear;
   assign do_pop  = pop && (count != '0);
   assign head    = (count != '0) ? mem[rd_ptr] : '0;

   // Entry storage, written on push.
   // NOTE: the array is deliberately not reset; entries are only ever read
   // when count says they hold data, so resetting them would buy nothing.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; clear dominates push and pop.
   // NOTE: registers are updated with non-blocking assignments so each one
   // samples the values from before the clock edge, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // The fetch credit scheme must never push into a full FIFO without a pop.
   assert property (@(posedge clk) disable iff (rst)
      !(do_push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch stage. Issues in-order word requests to a
// variable-latency instruction memory, buffers responses in ifu_fifo and
// hands them to decode with valid/ready. A redirect reloads the PC, clears
// the FIFO and drops every response still in flight.
// Optional build macro IFU_PERF_EN adds saturating performance counters
// (perf_fetched, perf_stall, perf_flush).
module instr_fetch_unit
   import mips_defs::*;
#(
   parameter logic [ADR_W-1:0] RESET_ADR = 16'h0000,
   parameter int               DEPTH     = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_en,
   input  logic [ADR_W-1:0] redirect_adr,
   output logic             imem_req,
   output logic [ADR_W-1:0] imem_adr,
   input  logic             imem_ack,
   input  logic             imem_rvalid,
   input  logic [INS_W-1:0] imem_rdata,
   output logic             ins_valid,
   input  logic             ins_ready,
   output logic [INS_W-1:0] ins_data,
   output logic [ADR_W-1:0] ins_pc
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_flush
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   ifu_state_t       state;
   ifu_state_t       state_nxt;
   logic             armed;
   logic [ADR_W-1:0] pc;
   logic [ADR_W-1:0] rsp_adr;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] discard_nxt;
   logic [CNT_W-1:0] out_after_rsp;
   logic [CNT_W:0]   credit_used;
   logic             issue;
   logic             pop;
   logic             push;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   assign issue         = imem_req && imem_ack;
   assign pop           = ins_valid && ins_ready;
   // Responses are kept only when nothing older is pending discard.
   assign push          = imem_rvalid && !redirect_en && (discard == '0);
   assign out_after_rsp = outstanding - CNT_W'(imem_rvalid);
   assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};

   // Responses come back in order, so the next kept response belongs to
   // rsp_adr; after a redirect the first kept one is the redirect target.
   assign push_entry.adr = rsp_adr;
   assign push_entry.ins = imem_rdata;

   ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_en),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign ins_valid = (fifo_count != '0);
   assign ins_data  = head.ins;
   assign ins_pc    = head.adr;
   assign imem_adr  = pc;

   // Discard count: a redirect covers everything still in flight, less a
   // response dropped in the same cycle; otherwise each response retires one.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      discard_nxt = discard;
      if (redirect_en)                          discard_nxt = out_after_rsp;
      else if (imem_rvalid && (discard != '0))  discard_nxt = discard - CNT_W'(1);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IFU_RUN;
      else     state <= state_nxt;
   end

   // FSM next state: drain while discarded responses are still due.
   always_comb begin
      state_nxt = state;
      case (state)
         IFU_RUN:   if (redirect_en && (out_after_rsp != '0)) state_nxt = IFU_DRAIN;
         IFU_DRAIN: if (discard_nxt == '0)                    state_nxt = IFU_RUN;
         default:   state_nxt = IFU_RUN;
      endcase
   end

   // FSM output: request while running, not redirecting, and with credit left.
   always_comb begin
      imem_req = 1'b0;
      if (armed && (state == IFU_RUN) && !redirect_en && (credit_used < (CNT_W+1)'(DEPTH)))
         imem_req = 1'b1;
   end

   // Holds requests off until the first clock edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) armed <= 1'b0;
      else     armed <= 1'b1;
   end

   // PC, response address and in-flight bookkeeping; redirect wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_ADR;
         rsp_adr     <= RESET_ADR;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         discard <= discard_nxt;
         if (redirect_en) begin
            pc          <= redirect_adr;
            rsp_adr     <= redirect_adr;
            outstanding <= out_after_rsp;
         end else begin
            if (issue) pc      <= pc + ADR_W'(1);
            if (push)  rsp_adr <= rsp_adr + ADR_W'(1);
            outstanding <= out_after_rsp + CNT_W'(issue);
         end
      end
   end

`ifdef IFU_PERF_EN
   // Saturating counters: pops (including one in a redirect cycle),
   // starved decode cycles, and redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         perf_fetched <= sat_inc(perf_fetched, pop);
         perf_stall   <= sat_inc(perf_stall, ins_ready && !ins_valid);
         perf_flush   <= sat_inc(perf_flush, redirect_en);
      end
   end
`endif

endmodule
